// File: rtl/load_store_unit_if.sv
// load_store_unit_if: request/response, data memory and statistics signals of the load/store unit
interface load_store_unit_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int TAG_W  = 6,
   parameter int CNT_W  = 16
);
   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic [TAG_W-1:0]  req_rd;
   logic              resp_valid;
   logic              resp_ready;
   logic [DATA_W-1:0] resp_rdata;
   logic [TAG_W-1:0]  resp_rd;
   logic              resp_err;
   logic              mem_read;
   logic              mem_wrt;
   logic [ADDR_W-1:0] mem_address;
   logic [DATA_W-1:0] mem_data_in;
   logic [DATA_W-1:0] mem_data_out;
   logic [CNT_W-1:0]  ld_cnt;
   logic [CNT_W-1:0]  st_cnt;
   logic [CNT_W-1:0]  err_cnt;

   modport master (
      output req_valid, req_write, req_addr, req_wdata, req_rd, resp_ready, mem_data_out,
      input  req_ready, resp_valid, resp_rdata, resp_rd, resp_err,
      input  mem_read, mem_wrt, mem_address, mem_data_in, ld_cnt, st_cnt, err_cnt
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, req_rd, resp_ready, mem_data_out,
      output req_ready, resp_valid, resp_rdata, resp_rd, resp_err,
      output mem_read, mem_wrt, mem_address, mem_data_in, ld_cnt, st_cnt, err_cnt
   );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store initiator for the data memory with debug counters
module load_store_unit #(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int MEM_DEPTH = 64,
   parameter int TAG_W     = 6,
   parameter int CNT_W     = 16
) (
   input logic               clk,
   input logic               rst_n,
   load_store_unit_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t            state_q, state_d;
   logic              write_q, write_d;
   logic [TAG_W-1:0]  rd_q, rd_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              err_q, err_d;
   logic [CNT_W-1:0]  ld_q, ld_d, st_q, st_d, ec_q, ec_d;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return &c ? c : c + 1'b1;
   endfunction

   // state and datapath registers; async reset clears everything including the strobes' source
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         write_q <= 1'b0;
         rd_q    <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         ld_q    <= '0;
         st_q    <= '0;
         ec_q    <= '0;
      end else begin
         state_q <= state_d;
         write_q <= write_d;
         rd_q    <= rd_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         ld_q    <= ld_d;
         st_q    <= st_d;
         ec_q    <= ec_d;
      end
   end

   // next state: out-of-range requests skip ACCESS, so memory strobes never fire for them
   always_comb begin
      state_d = state_q;
      write_d = write_q;
      rd_d    = rd_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      ld_d    = ld_q;
      st_d    = st_q;
      ec_d    = ec_q;
      case (state_q)
         IDLE: if (bus.req_valid) begin
            write_d = bus.req_write;
            rd_d    = bus.req_rd;
            if (bus.req_addr >= ADDR_W'(MEM_DEPTH)) begin
               state_d = RESP;
               err_d   = 1'b1;
               rdata_d = '0;
               ec_d    = sat_inc(ec_q);
            end else begin
               state_d = ACCESS;
               addr_d  = bus.req_addr;
               wdata_d = bus.req_wdata;
            end
         end
         ACCESS: begin
            state_d = RESP;
            err_d   = 1'b0;
            rdata_d = write_q ? '0 : bus.mem_data_out;
            ld_d    = write_q ? ld_q : sat_inc(ld_q);
            st_d    = write_q ? sat_inc(st_q) : st_q;
         end
         default: state_d = bus.resp_ready ? IDLE : RESP;
      endcase
   end

   assign bus.req_ready   = state_q == IDLE;
   assign bus.resp_valid  = state_q == RESP;
   assign bus.resp_rdata  = rdata_q;
   assign bus.resp_rd     = rd_q;
   assign bus.resp_err    = err_q;
   assign bus.mem_read    = state_q == ACCESS && !write_q;
   assign bus.mem_wrt     = state_q == ACCESS && write_q;
   assign bus.mem_address = addr_q;
   assign bus.mem_data_in = wdata_q;
   assign bus.ld_cnt      = ld_q;
   assign bus.st_cnt      = st_q;
   assign bus.err_cnt     = ec_q;
endmodule
